// File: rtl/decode_queue.sv
// Decode front end: DEPTH-entry instruction queue feeding a registered ID/EX
// control bundle, with load-use bubbles, branch flush and HALT latching.
module decode_queue #(
    parameter int DEPTH = 4,
    parameter int PCW   = 16,
    parameter int CNTW  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     if_valid,
    input  logic [15:0]              if_inst,
    input  logic [PCW-1:0]           if_pc,
    output logic                     if_ready,
    input  logic                     flush,
    input  logic                     ex_ready,
    output logic                     id_valid,
    output logic [15:0]              id_inst,
    output logic [PCW-1:0]           id_pc,
    output logic                     mem_read,
    output logic                     mem_write,
    output logic                     reg_write,
    output logic                     alu_src1,
    output logic                     alu_src2,
    output logic                     mem_to_reg,
    output logic                     out_en,
    output logic                     in_en,
    output logic                     alu_or_shift,
    output logic                     halt,
    output logic                     as_bc,
    output logic [3:0]               alu_op,
    output logic [2:0]               reg_dst,
    output logic [2:0]               branch_cond,
    output logic [$clog2(DEPTH):0]   q_count,
    output logic [CNTW-1:0]          stall_cnt,
    output logic                     halted
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = 21;
    localparam logic [0:0] RUN    = 1'b0;
    localparam logic [0:0] HALTED = 1'b1;
    localparam logic [CW-1:0] NOP_CTRL = {{(CW-3){1'b0}}, 3'b111};
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    // Control word layout, MSB first: mem_read, mem_write, reg_write, alu_src1,
    // alu_src2, mem_to_reg, out_en, in_en, alu_or_shift, halt, as_bc, alu_op, reg_dst, branch_cond
    function automatic logic [CW-1:0] decode(input logic [15:0] inst);
        logic [3:0] op;
        logic [2:0] bc;
        logic       mr, mw, rw, s1, s2, m2r, oe, ie, aos, hl, abc;
        logic [3:0] aop;
        logic [2:0] rd, brc;
        op  = inst[7:4];
        bc  = inst[13:11];
        mr  = 1'b0; mw = 1'b0; rw = 1'b0; s1 = 1'b0; s2 = 1'b1; m2r = 1'b0;
        oe  = 1'b0; ie = 1'b0; aos = 1'b0; hl = 1'b0; abc = 1'b0;
        aop = 4'b0000;
        rd  = inst[10:8];
        brc = 3'b111;
        case (inst[15:14])
            2'b00: begin
                mr  = 1'b1;
                rw  = 1'b1;
                m2r = 1'b1;
                rd  = inst[13:11];
            end
            2'b01: mw = 1'b1;
            2'b10: begin
                if (bc == 3'b000) begin
                    rw  = 1'b1;
                    aop = 4'b0110;
                end else begin
                    s1 = 1'b1;
                end
                if (bc == 3'b111)      brc = inst[10:8];
                else if (bc == 3'b100) brc = 3'b100;
            end
            default: begin
                aop = op;
                s2  = (op > 4'b0110);
                rw  = !(op inside {4'b0101, 4'b0111, 4'b1101, 4'b1110, 4'b1111});
                abc = !(op inside {4'b0111, 4'b1100, 4'b1101, 4'b1110, 4'b1111});
                m2r = (op == 4'b1100);
                ie  = (op == 4'b1100);
                oe  = (op == 4'b1101);
                aos = (op[3:2] == 2'b10);
                hl  = (op == 4'b1111);
            end
        endcase
        return {mr, mw, rw, s1, s2, m2r, oe, ie, aos, hl, abc, aop, rd, brc};
    endfunction

    function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic [15:0]     q_inst [DEPTH];
    logic [PCW-1:0]  q_pc   [DEPTH];
    logic [AW-1:0]   head, tail;
    logic [AW:0]     count;
    logic [0:0]      state;
    logic [CNTW-1:0] stall_q;

    logic            vld_p1;
    logic [15:0]     inst_p1;
    logic [PCW-1:0]  pc_p1;
    logic [CW-1:0]   ctrl_p1;

    logic [15:0] head_inst;
    logic        not_empty, id_load, id_halt, hazard, issue, push, bubble;

    assign head_inst = q_inst[head];
    assign not_empty = (count != '0);
    assign id_load   = vld_p1 && (inst_p1[15:14] == 2'b00);
    assign id_halt   = vld_p1 && ctrl_p1[11];
    assign hazard    = not_empty && id_load && (head_inst[15:14] != 2'b10) &&
                       ((head_inst[13:11] == ctrl_p1[5:3]) || (head_inst[10:8] == ctrl_p1[5:3]));
    assign issue     = (state == RUN) && not_empty && (!vld_p1 || ex_ready) && !id_halt && !hazard;
    assign bubble    = (state == RUN) && hazard && ex_ready;
    // Ready depends only on occupancy and state, never on a same-cycle pop.
    assign if_ready  = (count < FULL) && (state == RUN);
    assign push      = if_valid && if_ready && !flush;

    always_ff @(posedge clk) begin
        if (push) begin
            q_inst[tail] <= if_inst;
            q_pc[tail]   <= if_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            state   <= RUN;
            vld_p1  <= 1'b0;
            stall_q <= '0;
        end else if (flush) begin
            head   <= '0;
            tail   <= '0;
            count  <= '0;
            vld_p1 <= 1'b0;
        end else begin
            if (push)  tail <= tail + 1'b1;
            if (issue) head <= head + 1'b1;
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, issue};
            if (issue)         vld_p1 <= 1'b1;
            else if (ex_ready) vld_p1 <= 1'b0;
            if ((state == RUN) && id_halt && ex_ready) state <= HALTED;
            if (bubble) stall_q <= sat_inc(stall_q);
        end
    end

    // ID/EX register stage
    always_ff @(posedge clk) begin
        if (rst) begin
            inst_p1 <= '0;
            pc_p1   <= '0;
            ctrl_p1 <= NOP_CTRL;
        end else if (flush) begin
            ctrl_p1 <= NOP_CTRL;
        end else if (issue) begin
            inst_p1 <= head_inst;
            pc_p1   <= q_pc[head];
            ctrl_p1 <= decode(head_inst);
        end else if (ex_ready) begin
            ctrl_p1 <= NOP_CTRL;
        end
    end

    assign id_valid  = vld_p1;
    assign id_inst   = inst_p1;
    assign id_pc     = pc_p1;
    assign {mem_read, mem_write, reg_write, alu_src1, alu_src2, mem_to_reg, out_en,
            in_en, alu_or_shift, halt, as_bc, alu_op, reg_dst, branch_cond} = ctrl_p1;
    assign q_count   = count;
    assign stall_cnt = stall_q;
    assign halted    = (state == HALTED);
endmodule

// File: tb/tb_decode_queue.sv
// Self-checking bench for decode_queue: directed scenarios with literal checks
// plus randomized traffic compared every cycle against a queue-based model.
module tb_decode_queue;
    localparam int DEPTH = 4;
    localparam int PCW   = 16;
    localparam int CNTW  = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, if_valid, flush, ex_ready;
    logic [15:0] if_inst;
    logic [PCW-1:0] if_pc;
    logic if_ready, id_valid;
    logic [15:0] id_inst;
    logic [PCW-1:0] id_pc;
    logic mem_read, mem_write, reg_write, alu_src1, alu_src2, mem_to_reg;
    logic out_en, in_en, alu_or_shift, halt, as_bc;
    logic [3:0] alu_op;
    logic [2:0] reg_dst, branch_cond;
    logic [2:0] q_count;
    logic [CNTW-1:0] stall_cnt;
    logic halted;

    decode_queue #(.DEPTH(DEPTH), .PCW(PCW), .CNTW(CNTW)) dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc),
        .if_ready(if_ready), .flush(flush), .ex_ready(ex_ready), .id_valid(id_valid),
        .id_inst(id_inst), .id_pc(id_pc), .mem_read(mem_read), .mem_write(mem_write),
        .reg_write(reg_write), .alu_src1(alu_src1), .alu_src2(alu_src2),
        .mem_to_reg(mem_to_reg), .out_en(out_en), .in_en(in_en),
        .alu_or_shift(alu_or_shift), .halt(halt), .as_bc(as_bc), .alu_op(alu_op),
        .reg_dst(reg_dst), .branch_cond(branch_cond), .q_count(q_count),
        .stall_cnt(stall_cnt), .halted(halted)
    );

    logic [20:0] dut_ctrl;
    assign dut_ctrl = {mem_read, mem_write, reg_write, alu_src1, alu_src2, mem_to_reg, out_en,
                       in_en, alu_or_shift, halt, as_bc, alu_op, reg_dst, branch_cond};

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [31:0] mq[$];
    bit          m_vld;
    logic [15:0] m_inst;
    logic [15:0] m_pc;
    bit          m_halted;
    logic [15:0] m_stall;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [20:0] ref_ctrl(input logic [15:0] i);
        int cls, op, bc;
        bit mr, mw, rw, s1, s2, m2r, oe, ie, aos, hl, abc;
        logic [3:0] aop;
        logic [2:0] rd, brc;
        cls = int'(i[15:14]); op = int'(i[7:4]); bc = int'(i[13:11]);
        rw  = (cls == 0) || (cls == 2 && bc == 0) ||
              (cls == 3 && op != 5 && op != 7 && op != 13 && op != 14 && op != 15);
        mr  = (cls == 0);
        mw  = (cls == 1);
        m2r = (cls == 0) || (cls == 3 && op == 12);
        s1  = (cls == 2 && bc != 0);
        s2  = !(cls == 3 && op <= 6);
        oe  = (cls == 3 && op == 13);
        ie  = (cls == 3 && op == 12);
        aos = (cls == 3 && op >= 8 && op <= 11);
        hl  = (cls == 3 && op == 15);
        abc = (cls == 3 && !(op == 7 || op >= 12));
        aop = (cls == 3) ? i[7:4] : ((cls == 2 && bc == 0) ? 4'd6 : 4'd0);
        brc = (cls == 2 && bc == 7) ? i[10:8] : ((cls == 2 && bc == 4) ? 3'd4 : 3'd7);
        rd  = (cls == 0) ? i[13:11] : i[10:8];
        return {mr, mw, rw, s1, s2, m2r, oe, ie, aos, hl, abc, aop, rd, brc};
    endfunction

    task automatic compare_all();
        chk("id_valid", {31'd0, id_valid}, {31'd0, m_vld});
        if (m_vld) begin
            chk("id_inst", {16'd0, id_inst}, {16'd0, m_inst});
            chk("id_pc", {16'd0, id_pc}, {16'd0, m_pc});
        end
        chk("ctrl", {11'd0, dut_ctrl}, {11'd0, m_vld ? ref_ctrl(m_inst) : 21'h7});
        chk("q_count", {29'd0, q_count}, mq.size());
        chk("stall_cnt", {16'd0, stall_cnt}, {16'd0, m_stall});
        chk("halted", {31'd0, halted}, {31'd0, m_halted});
        chk("if_ready", {31'd0, if_ready}, {31'd0, (mq.size() < DEPTH) && !m_halted});
    endtask

    task automatic model_update(input bit r, input bit v, input logic [15:0] inst,
                                input logic [15:0] pc, input bit f, input bit e);
        bit rdy, do_push, haz, is_halt, iss;
        logic [31:0] h;
        rdy = (mq.size() < DEPTH) && !m_halted;
        if (r) begin
            mq.delete(); m_vld = 0; m_inst = '0; m_pc = '0; m_halted = 0; m_stall = '0;
        end else if (f) begin
            mq.delete(); m_vld = 0;
        end else begin
            do_push = v && rdy;
            haz = 0;
            is_halt = m_vld && m_inst[15:14] == 2'b11 && m_inst[7:4] == 4'hF;
            if (mq.size() > 0) begin
                h = mq[0];
                haz = m_vld && m_inst[15:14] == 2'b00 && h[31:30] != 2'b10 &&
                      (h[29:27] == m_inst[13:11] || h[26:24] == m_inst[13:11]);
            end
            iss = !m_halted && mq.size() > 0 && (!m_vld || e) && !is_halt && !haz;
            if (haz && e && !m_halted && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
            if (is_halt && e) m_halted = 1;
            if (iss) begin
                h = mq.pop_front();
                m_vld = 1; m_inst = h[31:16]; m_pc = h[15:0];
            end else if (e) begin
                m_vld = 0;
            end
            if (do_push) mq.push_back({inst, pc});
        end
    endtask

    task automatic step(input bit r, input bit v, input logic [15:0] inst,
                        input logic [15:0] pc, input bit f, input bit e);
        rst = r; if_valid = v; if_inst = inst; if_pc = pc; flush = f; ex_ready = e;
        model_update(r, v, inst, pc, f, e);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 16'h0, 16'h0, 0, 1);
    endtask

    initial begin
        bit r, v, f, e;
        logic [15:0] inst, pc;
        m_vld = 0; m_inst = '0; m_pc = '0; m_halted = 0; m_stall = '0;
        step(1, 0, 16'h0, 16'h0, 0, 0);
        step(1, 0, 16'h0, 16'h0, 0, 0);
        chk("rst_id_valid", {31'd0, id_valid}, 32'd0);
        chk("rst_id_inst", {16'd0, id_inst}, 32'd0);
        chk("rst_bcond", {29'd0, branch_cond}, 32'd7);
        chk("rst_q_count", {29'd0, q_count}, 32'd0);
        chk("rst_if_ready", {31'd0, if_ready}, 32'd1);

        // ADD then SUB
        step(0, 1, 16'hC000, 16'h0010, 0, 1);
        chk("add_not_yet", {31'd0, id_valid}, 32'd0);
        step(0, 1, 16'hC010, 16'h0012, 0, 1);
        chk("add_valid", {31'd0, id_valid}, 32'd1);
        chk("add_aluop", {28'd0, alu_op}, 32'd0);
        chk("add_src2", {31'd0, alu_src2}, 32'd0);
        chk("add_rw", {31'd0, reg_write}, 32'd1);
        chk("add_asbc", {31'd0, as_bc}, 32'd1);
        step(0, 0, 16'h0, 16'h0, 0, 1);
        chk("sub_aluop", {28'd0, alu_op}, 32'd1);
        chk("sub_inst", {16'd0, id_inst}, 32'hC010);
        idle(2);

        // Load-use bubble, then independent consumer
        step(0, 1, 16'h1800, 16'h0020, 0, 1);
        step(0, 1, 16'hC300, 16'h0021, 0, 1);
        chk("ld_memread", {31'd0, mem_read}, 32'd1);
        step(0, 0, 16'h0, 16'h0, 0, 1);
        chk("bubble_valid", {31'd0, id_valid}, 32'd0);
        chk("bubble_stall", {16'd0, stall_cnt}, 32'd1);
        chk("bubble_bcond", {29'd0, branch_cond}, 32'd7);
        step(0, 0, 16'h0, 16'h0, 0, 1);
        chk("after_bubble", {16'd0, id_inst}, 32'hC300);
        step(0, 1, 16'h1800, 16'h0030, 0, 1);
        step(0, 1, 16'hC500, 16'h0031, 0, 1);
        step(0, 0, 16'h0, 16'h0, 0, 1);
        chk("nohaz_inst", {16'd0, id_inst}, 32'hC500);
        chk("nohaz_stall", {16'd0, stall_cnt}, 32'd1);
        idle(2);

        // Fill with EX blocked, then drain
        for (int k = 0; k < 6; k++) step(0, 1, 16'hC000 | 16'(k << 4), 16'(16'h40 + k), 0, 0);
        chk("full_count", {29'd0, q_count}, 32'd4);
        chk("full_ready", {31'd0, if_ready}, 32'd0);
        idle(6);

        // Flush with concurrent push
        for (int k = 0; k < 4; k++) step(0, 1, 16'hC010, 16'(16'h50 + k), 0, 0);
        step(0, 1, 16'hC020, 16'h0060, 1, 0);
        chk("flush_count", {29'd0, q_count}, 32'd0);
        chk("flush_valid", {31'd0, id_valid}, 32'd0);
        idle(3);

        // HALT
        step(0, 1, 16'hC0F0, 16'h0070, 0, 1);
        step(0, 1, 16'hC000, 16'h0071, 0, 1);
        chk("hlt_halt", {31'd0, halt}, 32'd1);
        step(0, 0, 16'h0, 16'h0, 0, 1);
        chk("hlt_halted", {31'd0, halted}, 32'd1);
        chk("hlt_ready", {31'd0, if_ready}, 32'd0);
        idle(3);
        step(0, 0, 16'h0, 16'h0, 1, 1);
        chk("hlt_flush", {31'd0, halted}, 32'd1);
        step(1, 0, 16'h0, 16'h0, 0, 1);
        chk("hlt_rst", {31'd0, halted}, 32'd0);

        // Branch and LI decode
        step(0, 1, 16'hBA00, 16'h0080, 0, 1);
        step(0, 0, 16'h0, 16'h0, 0, 1);
        chk("br_cond", {29'd0, branch_cond}, 32'd2);
        chk("br_src1", {31'd0, alu_src1}, 32'd1);
        step(0, 1, 16'h8100, 16'h0081, 0, 1);
        step(0, 0, 16'h0, 16'h0, 0, 1);
        chk("li_rw", {31'd0, reg_write}, 32'd1);
        chk("li_aluop", {28'd0, alu_op}, 32'd6);
        chk("li_src1", {31'd0, alu_src1}, 32'd0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            r = ($urandom_range(0, 299) == 0) || (m_halted && $urandom_range(0, 15) == 0);
            v = ($urandom_range(0, 3) != 0);
            inst = 16'($urandom);
            if (inst[15:14] == 2'b11 && inst[7:4] == 4'hF && $urandom_range(0, 7) != 0)
                inst[7:4] = 4'h3;
            if ($urandom_range(0, 3) == 0) inst[15:14] = 2'b00;
            pc = 16'($urandom);
            f = ($urandom_range(0, 39) == 0);
            e = ($urandom_range(0, 3) != 0);
            step(r, v, inst, pc, f, e);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
